mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/ed25519_pkg.sv | 18 +
 rtl/mul_arbiter_rr_pick.sv | 28 ++
 rtl/mul_arbiter.sv | 128 ++++++++++++
 tb/tb_mul_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ed25519_pkg.sv
// Shared field constants and arbiter state encoding for the Ed25519 multiplier complex.
// Q is the field prime 2^255-19; D is the twisted Edwards curve constant.
package ed25519_pkg;

  localparam int W = 255;

  localparam logic [W-1:0] Q = {{(W-5){1'b1}}, 5'b01101};
  localparam logic [W-1:0] D =
    W'(256'h52036cee2b6ffe738cc740797779e89800700a4d4141d8ab75eb4dca135978a3);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mul_arbiter_rr_pick.sv
// Round-robin picker: first set bit of valid_i at or after ptr_i, wrapping modulo N.
// Purely combinational; found_o low when no bit is set.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  logic [IW-1:0] k;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    k       = '0;
    for (int i = 0; i < N; i++) begin
      k = IW'((int'(ptr_i) + i) % N);
      if (!found_o && valid_i[k]) begin
        found_o = 1'b1;
        idx_o   = k;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one modular multiplier between N requesters, one operation in flight at a time.
// Round-robin arbitration with an optional per-owner lock that holds the grant across operations.
module mul_arbiter
  import ed25519_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = ed25519_pkg::W,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N-1:0]    i_req_valid,
  output logic [N-1:0]    o_req_ready,
  input  logic [N-1:0]    i_req_lock,
  input  logic [N*W-1:0]  i_req_a,
  input  logic [N*W-1:0]  i_req_b,
  output logic [N-1:0]    o_rsp_valid,
  input  logic [N-1:0]    i_rsp_ready,
  output logic [W-1:0]    o_rsp_data,
  output logic            o_mul_start,
  output logic [W-1:0]    o_mul_a,
  output logic [W-1:0]    o_mul_b,
  input  logic            i_mul_done,
  input  logic [W-1:0]    i_mul_p,
  output logic            o_busy,
  output logic [IW-1:0]   o_grant_id
);

  arb_state_e    state_q;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] id_q;
  logic          lock_req_q;
  logic          lock_act_q;
  logic [IW-1:0] lock_id_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  p_q;

  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic [IW-1:0] win_d;
  logic          win_ok_d;
  logic [W-1:0]  sel_a_d;
  logic [W-1:0]  sel_b_d;
  logic          accept_d;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .valid_i (i_req_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  // An active lock pins the winner to its owner even while the owner has nothing pending.
  always_comb begin
    win_d       = lock_act_q ? lock_id_q : pick_idx;
    win_ok_d    = lock_act_q ? i_req_valid[win_d] : pick_found;
    accept_d    = (state_q == ST_IDLE) && win_ok_d;
    o_req_ready = '0;
    o_rsp_valid = '0;
    sel_a_d     = '0;
    sel_b_d     = '0;
    for (int k = 0; k < N; k++) begin
      if (win_d == IW'(k)) begin
        sel_a_d        = i_req_a[k*W +: W];
        sel_b_d        = i_req_b[k*W +: W];
        o_req_ready[k] = accept_d;
      end
      if (id_q == IW'(k)) begin
        o_rsp_valid[k] = (state_q == ST_RESP);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      lock_req_q <= 1'b0;
      lock_act_q <= 1'b0;
      lock_id_q  <= '0;
      a_q        <= '0;
      b_q        <= '0;
      p_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            a_q        <= sel_a_d;
            b_q        <= sel_b_d;
            id_q       <= win_d;
            lock_req_q <= i_req_lock[win_d];
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (i_mul_done) begin
            p_q     <= i_mul_p;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready[id_q]) begin
            state_q <= ST_IDLE;
            if (lock_req_q) begin
              lock_act_q <= 1'b1;
              lock_id_q  <= id_q;
            end else begin
              lock_act_q <= 1'b0;
              rr_ptr_q   <= (id_q == IW'(N-1)) ? '0 : id_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_mul_start = (state_q == ST_ISSUE);
  assign o_mul_a     = a_q;
  assign o_mul_b     = b_q;
  assign o_rsp_data  = p_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_grant_id  = o_busy ? id_q : rr_ptr_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a fixed-latency (L=5) modular multiplier model.
module tb_mul_arbiter;
  import ed25519_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int L  = 5;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic [N-1:0]    i_req_valid;
  logic [N-1:0]    o_req_ready;
  logic [N-1:0]    i_req_lock;
  logic [N*W-1:0]  i_req_a;
  logic [N*W-1:0]  i_req_b;
  logic [N-1:0]    o_rsp_valid;
  logic [N-1:0]    i_rsp_ready;
  logic [W-1:0]    o_rsp_data;
  logic            o_mul_start;
  logic [W-1:0]    o_mul_a;
  logic [W-1:0]    o_mul_b;
  logic            i_mul_done;
  logic [W-1:0]    i_mul_p;
  logic            o_busy;
  logic [IW-1:0]   o_grant_id;

  logic [W-1:0] a_tbl   [N];
  logic [W-1:0] b_tbl   [N];
  logic [W-1:0] exp_tbl [N];
  logic         stray_done;
  int           mcnt;
  logic [W-1:0] mprod;
  int           n_err = 0;
  int           n_chk = 0;

  always #5 i_clk = ~i_clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign i_req_a[g*W +: W] = a_tbl[g];
    assign i_req_b[g*W +: W] = b_tbl[g];
  end

  mul_arbiter #(.N(N), .W(W)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_lock  (i_req_lock),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_mul_start (o_mul_start),
    .o_mul_a     (o_mul_a),
    .o_mul_b     (o_mul_b),
    .i_mul_done  (i_mul_done),
    .i_mul_p     (i_mul_p),
    .o_busy      (o_busy),
    .o_grant_id  (o_grant_id)
  );

  function automatic logic [W-1:0] modmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] f;
    f = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    f = f % {{W{1'b0}}, Q};
    return f[W-1:0];
  endfunction

  // Multiplier model: done pulses L cycles after the start cycle; cleared by the shared reset.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mcnt  <= 0;
      mprod <= '0;
    end else if (o_mul_start) begin
      mcnt  <= L;
      mprod <= modmul(o_mul_a, o_mul_b);
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
    end
  end
  assign i_mul_done = (mcnt == 1) || stray_done;
  assign i_mul_p    = mprod;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  // One full transaction for whichever requester the DUT grants; returns that index.
  task automatic serve(input string tag, output int idx);
    int n;
    idx = -1;
    n   = 0;
    #1;
    while (o_req_ready == '0 && n < 20) begin
      tick();
      n++;
    end
    if (o_req_ready == '0) begin
      chk({tag, "_grant_timeout"}, W'(1), W'(0));
      return;
    end
    for (int k = 0; k < N; k++) if (o_req_ready[k]) idx = k;
    tick();
    n = 0;
    while (o_rsp_valid == '0 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_rsp_vld"}, W'(o_rsp_valid), W'(4'b0001 << idx));
    chk({tag, "_rsp_dat"}, o_rsp_data, exp_tbl[idx]);
    i_rsp_ready[idx] = 1'b1;
    tick();
    i_rsp_ready = '0;
  endtask

  initial begin
    int n;
    int g;
    int order_exp [6];
    i_rst_n     = 1'b0;
    i_req_valid = '0;
    i_req_lock  = '0;
    i_rsp_ready = '0;
    stray_done  = 1'b0;
    for (int k = 0; k < N; k++) begin
      a_tbl[k]   = W'(k + 1);
      b_tbl[k]   = W'(k + 10);
      exp_tbl[k] = W'((k + 1) * (k + 10));
    end
    tick();
    tick();
    chk("rst_busy",  W'(o_busy), W'(0));
    chk("rst_ctl",   W'({o_req_ready, o_rsp_valid, o_mul_start}), W'(0));
    chk("rst_data",  o_rsp_data | o_mul_a | o_mul_b, W'(0));
    chk("rst_gid",   W'(o_grant_id), W'(0));
    i_rst_n = 1'b1;
    tick();

    // Single request from requester 2: 2*3, latency check.
    a_tbl[2] = W'(2); b_tbl[2] = W'(3); exp_tbl[2] = W'(6);
    i_req_valid = 4'b0100;
    #1;
    chk("single_rdy", W'(o_req_ready), W'(4'b0100));
    tick();
    i_req_valid = '0;
    chk("single_start", W'(o_mul_start), W'(1));
    chk("single_ops", {o_mul_a[W-9:0], o_mul_b[7:0]}, W'({8'd2, 8'd3}));
    chk("single_gid", W'(o_grant_id), W'(2));
    n = 0;
    while (!o_rsp_valid[2] && n < 40) begin
      tick();
      n++;
    end
    chk("single_lat", W'(n), W'(6));
    chk("single_vld", W'(o_rsp_valid), W'(4'b0100));
    chk("single_dat", o_rsp_data, W'(6));
    i_rsp_ready[2] = 1'b1;
    tick();
    i_rsp_ready = '0;
    chk("single_idle", W'(o_busy), W'(0));
    chk("single_ptr", W'(o_grant_id), W'(3));
    exp_tbl[2] = W'(33); a_tbl[2] = W'(3); b_tbl[2] = W'(11);

    // Round robin with all four requesters continuously valid.
    do_reset();
    order_exp = '{0, 1, 2, 3, 0, 1};
    i_req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      serve("rr", g);
      chk($sformatf("rr_order%0d", i), W'(g), W'(order_exp[i]));
    end
    i_req_valid = '0;

    // Lock: requester 1 holds the multiplier for three operations.
    do_reset();
    i_req_valid = 4'b0001;
    serve("lk_pre", g);
    i_req_valid = 4'b1011;
    i_req_lock  = 4'b0010;
    serve("lk1", g);
    chk("lk1_id", W'(g), W'(1));
    i_req_valid = 4'b1001;
    #1;
    chk("lk_owner_idle_rdy", W'(o_req_ready), W'(0));
    tick();
    tick();
    chk("lk_owner_idle_hold", W'({o_req_ready, o_busy}), W'(0));
    i_req_valid = 4'b1011;
    serve("lk2", g);
    chk("lk2_id", W'(g), W'(1));
    i_req_lock = 4'b0000;
    serve("lk3", g);
    chk("lk3_id", W'(g), W'(1));
    i_req_valid = 4'b1001;
    serve("lk4", g);
    chk("lk4_id", W'(g), W'(3));
    serve("lk5", g);
    chk("lk5_id", W'(g), W'(0));
    i_req_valid = '0;

    // Response backpressure: result held, nothing else accepted or started.
    do_reset();
    i_req_valid = 4'b0011;
    #1;
    chk("bp_rdy", W'(o_req_ready), W'(4'b0001));
    tick();
    n = 0;
    while (o_rsp_valid == '0 && n < 40) begin
      tick();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_hold%0d", i),
          {o_rsp_valid, o_req_ready, o_mul_start, o_rsp_data[W-10:0]},
          {4'b0001, 4'b0000, 1'b0, exp_tbl[0][W-10:0]});
      tick();
    end
    i_rsp_ready[0] = 1'b1;
    tick();
    i_rsp_ready = '0;
    serve("bp_next", g);
    chk("bp_next_id", W'(g), W'(1));
    i_req_valid = '0;

    // Reset during WAIT, then a late done pulse.
    do_reset();
    i_req_valid = 4'b0100;
    tick();
    i_req_valid = '0;
    tick();
    tick();
    chk("mid_wait_busy", W'(o_busy), W'(1));
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", W'({o_req_ready, o_rsp_valid, o_mul_start, o_busy, o_grant_id}), W'(0));
    chk("mid_rst_dat", o_rsp_data | o_mul_a | o_mul_b, W'(0));
    tick();
    i_rst_n = 1'b1;
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("late_done_ign", W'({o_rsp_valid, o_busy}), W'(0));
    i_req_valid = 4'b0101;
    serve("post_rst", g);
    chk("post_rst_id", W'(g), W'(0));
    i_req_valid = '0;

    // Boundary operands Q-1 squared, then a stray done while idle.
    a_tbl[1] = Q - W'(1); b_tbl[1] = Q - W'(1); exp_tbl[1] = W'(1);
    i_req_valid = 4'b0010;
    serve("qm1", g);
    i_req_valid = '0;
    chk("qm1_id", W'(g), W'(1));
    chk("qm1_hold_a", o_mul_a, Q - W'(1));
    chk("qm1_ptr", W'(o_grant_id), W'(2));
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    tick();
    chk("stray_idle", W'({o_rsp_valid, o_busy}), W'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
